// File: rtl/relu_rr_arbiter.sv
// relu_rr_arbiter: round-robin, burst-locked sharing of one ReLU datapath between NUM_REQ streams.
// Defining RELU_ARB_BYPASS_EN adds the relu_bypass input, which passes accepted words through unmodified.

module relu (
  input  logic [31:0] i_data,
  output logic [31:0] o_data
);

  // A word with bit 30 set is clamped to zero
  always_comb begin
    if (i_data[30]) begin
      o_data = 32'h0000_0000;
    end else begin
      o_data = i_data;
    end
  end

endmodule

module relu_rr_arbiter #(
  parameter  int NUM_REQ = 4,
  parameter  int BURST   = 8,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [32*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]    req_last,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  out_valid,
  output logic [31:0]           out_data,
  output logic [ID_W-1:0]       out_id,
  output logic                  out_last,
  input  logic                  out_ready,
`ifdef RELU_ARB_BYPASS_EN
  input  logic                  relu_bypass,
`endif
  output logic                  busy
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [ID_W-1:0] r_ptr;
  logic [ID_W-1:0] r_gnt;
  logic [7:0]      r_beat_cnt;
  logic            r_out_valid;
  logic [31:0]     r_out_data;
  logic [ID_W-1:0] r_out_id;
  logic            r_out_last;

  logic [ID_W:0]   w_sum  [NUM_REQ];
  logic [ID_W-1:0] w_cand [NUM_REQ];
  logic [ID_W-1:0] w_sel;
  logic            w_found;
  logic [31:0]     w_sel_data;
  logic            w_sel_last;
  logic [31:0]     w_relu_out;
  logic [31:0]     w_load_data;
  logic            w_gnt_ready;
  logic            w_accept;
  logic            w_release;

  // Candidate k is requester (ptr + 1 + k) mod NUM_REQ, i.e. scan order starting after ptr
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum[k] = {1'b0, r_ptr} + (ID_W+1)'(k + 1);
      if (w_sum[k] >= (ID_W+1)'(NUM_REQ)) begin
        w_cand[k] = ID_W'(w_sum[k] - (ID_W+1)'(NUM_REQ));
      end else begin
        w_cand[k] = w_sum[k][ID_W-1:0];
      end
    end
  end

  // Walk candidates from last to first so the earliest valid one in scan order wins
  always_comb begin
    w_found = |req_valid;
    w_sel   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_sel = req_valid[w_cand[k]] ? w_cand[k] : w_sel;
    end
  end

  // Route the granted requester's word and last flag to the datapath
  always_comb begin
    w_sel_data = 32'h0000_0000;
    w_sel_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sel_data = (r_gnt == ID_W'(i)) ? req_data[32*i +: 32] : w_sel_data;
      w_sel_last = (r_gnt == ID_W'(i)) ? req_last[i]          : w_sel_last;
    end
  end

  relu u_relu (
    .i_data (w_sel_data),
    .o_data (w_relu_out)
  );

`ifdef RELU_ARB_BYPASS_EN
  assign w_load_data = relu_bypass ? w_sel_data : w_relu_out;
`else
  assign w_load_data = w_relu_out;
`endif

  assign w_gnt_ready = !r_out_valid || out_ready;
  assign w_accept    = (r_state == S_GRANT) && req_valid[r_gnt] && w_gnt_ready;
  assign w_release   = w_accept && ((r_beat_cnt == 8'(BURST - 1)) || w_sel_last);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: a grant stays locked until its burst limit or a last word
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = w_found   ? S_GRANT : S_IDLE;
      S_GRANT: w_state_nxt = w_release ? S_IDLE  : S_GRANT;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: only the owner may see ready, and only when the output slot can take a word
  always_comb begin
    req_ready = '0;
    busy      = r_out_valid;
    case (r_state)
      S_GRANT: begin
        req_ready[r_gnt] = w_gnt_ready;
        busy             = 1'b1;
      end
      default: begin
        req_ready = '0;
        busy      = r_out_valid;
      end
    endcase
  end

  // Grant owner, round-robin pointer and beat counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr      <= ID_W'(NUM_REQ - 1);
      r_gnt      <= '0;
      r_beat_cnt <= 8'd0;
    end else if ((r_state == S_IDLE) && w_found) begin
      r_gnt      <= w_sel;
      r_beat_cnt <= 8'd0;
    end else if (w_accept) begin
      r_beat_cnt <= r_beat_cnt + 8'd1;
      r_ptr      <= w_release ? r_gnt : r_ptr;
    end
  end

  // One-entry output register; a load wins over a drain in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= 32'h0000_0000;
      r_out_id    <= '0;
      r_out_last  <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_load_data;
      r_out_id    <= r_gnt;
      r_out_last  <= w_sel_last;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_id    = r_out_id;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_relu_rr_arbiter.sv
// Bench for relu_rr_arbiter: directed scenarios plus randomized traffic checked against a
// transaction-level arbitration/scoreboard model.

module tb_relu_rr_arbiter;

  localparam int NUM_REQ = 4;
  localparam int BURST   = 8;
  localparam int ID_W    = $clog2(NUM_REQ);

  typedef struct packed {
    logic            last;
    logic [ID_W-1:0] id;
    logic [31:0]     data;
  } word_t;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    req_valid;
  logic [32*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]    req_last;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  out_valid;
  logic [31:0]           out_data;
  logic [ID_W-1:0]       out_id;
  logic                  out_last;
  logic                  out_ready;
  logic                  busy;
  logic                  tb_bypass;

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;

  logic [32:0]        src_q [NUM_REQ][$];
  logic [NUM_REQ-1:0] src_en;
  word_t              exp_q [$];
  logic [31:0]        log_d [$];
  int                 log_id [$];
  logic               log_last [$];

  bit m_grant;
  int m_gnt;
  int m_ptr;
  int m_cnt;

  always #5 clk = ~clk;

  relu_rr_arbiter #(.NUM_REQ(NUM_REQ), .BURST(BURST)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_last  (out_last),
    .out_ready (out_ready),
`ifdef RELU_ARB_BYPASS_EN
    .relu_bypass (tb_bypass),
`endif
    .busy      (busy)
  );

  function automatic logic [31:0] relu_ref(input logic [31:0] d);
    return d[30] ? 32'h0000_0000 : d;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_grant = 1'b0;
    m_gnt   = 0;
    m_ptr   = NUM_REQ - 1;
    m_cnt   = 0;
    n_acc   = 0;
    exp_q.delete();
    log_d.delete();
    log_id.delete();
    log_last.delete();
    for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
    src_en = '0;
  endtask

  task automatic drive();
    logic [32:0] w;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (src_en[i] && src_q[i].size() > 0) begin
        w = src_q[i][0];
        req_valid[i]          = 1'b1;
        req_data[32*i +: 32]  = w[31:0];
        req_last[i]           = w[32];
      end else begin
        req_valid[i]          = 1'b0;
        req_data[32*i +: 32]  = 32'h0000_0000;
        req_last[i]           = 1'b0;
      end
    end
  endtask

  // One clock: check outputs against the model at negedge, advance model, then pass the edge
  task automatic run_cycle();
    logic [NUM_REQ-1:0] exp_ready;
    logic [31:0]        d;
    word_t              w;
    bit                 found;
    int                 idx;
    @(negedge clk);
    exp_ready = '0;
    if (m_grant && (exp_q.size() == 0 || out_ready)) exp_ready[m_gnt] = 1'b1;
    chk("req_ready", req_ready, exp_ready);
    chk("out_valid", out_valid, (exp_q.size() != 0));
    chk("busy", busy, (m_grant || exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk("out_data", out_data, exp_q[0].data);
      chk("out_id",   out_id,   exp_q[0].id);
      chk("out_last", out_last, exp_q[0].last);
    end
    if (out_valid && out_ready) begin
      log_d.push_back(out_data);
      log_id.push_back(int'(out_id));
      log_last.push_back(out_last);
    end
    if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
    if (m_grant) begin
      if (exp_ready[m_gnt] && req_valid[m_gnt]) begin
        d      = req_data[32*m_gnt +: 32];
        w.data = tb_bypass ? d : relu_ref(d);
        w.id   = ID_W'(m_gnt);
        w.last = req_last[m_gnt];
        exp_q.push_back(w);
        m_cnt++;
        if (m_cnt == BURST || req_last[m_gnt]) begin
          m_ptr   = m_gnt;
          m_grant = 1'b0;
        end
      end
    end else if (req_valid != '0) begin
      found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
        idx = (m_ptr + k) % NUM_REQ;
        if (!found && req_valid[idx]) begin
          found = 1'b1;
          m_gnt = idx;
        end
      end
      m_grant = 1'b1;
      m_cnt   = 0;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        n_acc++;
        void'(src_q[i].pop_front());
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      drive();
      run_cycle();
    end
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    m_reset();
    drive();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] held;
    logic [32:0] w;
    rst_n     = 1'b0;
    out_ready = 1'b1;
    tb_bypass = 1'b0;
    m_reset();
    drive();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset values
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_id",   out_id,   32'h0);
    chk("rst_out_last", out_last, 32'h0);
    run(1);

    // Single requester, ReLU on bit 30
    do_reset();
    src_q[0].push_back({1'b0, 32'h3F80_0000});
    src_q[0].push_back({1'b0, 32'h4040_0000});
    src_en = 4'b0001;
    run(6);
    chk("t1_count", log_d.size(), 32'd2);
    chk("t1_w0", log_d[0], 32'h3F80_0000);
    chk("t1_w1", log_d[1], 32'h0000_0000);
    chk("t1_id0", log_id[0], 32'd0);
    chk("t1_id1", log_id[1], 32'd0);

    // All four continuously valid: 8-word grants in order 0,1,2,3,0 with a bubble between
    do_reset();
    for (int i = 0; i < NUM_REQ; i++)
      for (int j = 0; j < 16; j++) src_q[i].push_back({1'b0, 32'(i * 256 + j)});
    src_en = '1;
    run(45);
    chk("t2_accepted", n_acc, 32'd40);
    chk("t2_g0", log_id[0], 32'd0);
    chk("t2_g0_end", log_id[7], 32'd0);
    chk("t2_g1", log_id[8], 32'd1);
    chk("t2_g2", log_id[16], 32'd2);
    chk("t2_g3", log_id[24], 32'd3);
    chk("t2_g4", log_id[32], 32'd0);

    // Requester 2 ends its grant early with last on the 3rd word
    do_reset();
    for (int j = 1; j <= 5; j++) src_q[2].push_back({(j == 3), 32'(32'h200 + j)});
    for (int j = 1; j <= 4; j++) src_q[3].push_back({1'b0, 32'(32'h300 + j)});
    src_en = '1;
    run(15);
    chk("t3_id0", log_id[0], 32'd2);
    chk("t3_id2", log_id[2], 32'd2);
    chk("t3_last1", log_last[1], 32'd0);
    chk("t3_last2", log_last[2], 32'd1);
    chk("t3_next", log_id[3], 32'd3);

    // Output stall for 5 cycles mid-burst
    do_reset();
    for (int j = 1; j <= 10; j++) src_q[1].push_back({1'b0, 32'(j)});
    src_en = 4'b0010;
    run(3);
    held = out_data;
    chk("t4_held", held, 32'd2);
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      run(1);
      chk("t4_stall_ready", req_ready, 32'h0);
      chk("t4_stall_data", out_data, held);
    end
    out_ready = 1'b1;
    run(20);
    chk("t4_count", log_d.size(), 32'd10);
    for (int k = 0; k < 10; k++) chk("t4_seq", log_d[k], 32'(k + 1));

    // Asynchronous reset during a grant with a word held in the output register
    do_reset();
    src_q[0].push_back({1'b0, 32'h0000_0AB1});
    src_q[0].push_back({1'b1, 32'h0000_0AB2});
    src_q[1].push_back({1'b1, 32'h0000_0BB1});
    src_en    = 4'b0011;
    out_ready = 1'b0;
    run(3);
    chk("t5_pre_valid", out_valid, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_out_valid", out_valid, 32'h0);
    chk("t5_out_data", out_data, 32'h0);
    chk("t5_out_id", out_id, 32'h0);
    chk("t5_out_last", out_last, 32'h0);
    chk("t5_busy", busy, 32'h0);
    chk("t5_req_ready", req_ready, 32'h0);
    m_reset();
    src_q[1].push_back({1'b1, 32'h0000_0C01});
    src_q[2].push_back({1'b1, 32'h0000_0C02});
    src_en    = 4'b0110;
    out_ready = 1'b1;
    drive();
    @(posedge clk);
    #1 rst_n = 1'b1;
    run(5);
    chk("t5_first_gnt", log_id[0], 32'd1);

`ifdef RELU_ARB_BYPASS_EN
    // Bypass passes the word unmodified; without it the same word is clamped
    do_reset();
    src_q[0].push_back({1'b0, 32'h4040_0000});
    src_q[0].push_back({1'b0, 32'h4040_0000});
    src_en    = 4'b0001;
    tb_bypass = 1'b1;
    run(2);
    tb_bypass = 1'b0;
    run(3);
    chk("t6_bypass", log_d[0], 32'h4040_0000);
    chk("t6_relu", log_d[1], 32'h0000_0000);
`endif

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        while (src_q[i].size() < 2) begin
          w = {($urandom_range(0, 7) == 0), 32'($urandom())};
          src_q[i].push_back(w);
        end
        src_en[i] = ($urandom_range(0, 3) != 0);
      end
      out_ready = ($urandom_range(0, 4) != 0);
      run(1);
    end
    src_en    = '0;
    out_ready = 1'b1;
    run(3);
    chk("t7_drained", out_valid, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
